// File: rtl/match_event_logger_pkg.sv
// rtl/match_event_logger_pkg.sv - shared default widths and depth for the match event logger
package match_event_logger_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/match_event_logger_if.sv
// rtl/match_event_logger_if.sv - timestamp read stream between logger and reader
interface match_event_logger_if
    import match_event_logger_pkg::*;
#(
    parameter int TS_W = TS_W_DEF
);

    logic [TS_W-1:0] ts_data;
    logic            ts_valid;
    logic            ts_ready;

    modport master (output ts_data, output ts_valid, input  ts_ready);
    modport slave  (input  ts_data, input  ts_valid, output ts_ready);

endinterface

// File: rtl/match_event_logger_fifo.sv
// rtl/match_event_logger_fifo.sv - first-word fall-through FIFO with registered head output
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_head;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [AW:0]      w_rd_next;
    logic [WIDTH-1:0] w_head_next;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_pop     = i_pop & ~w_empty;
    assign w_push    = i_push & (~w_full | w_pop);
    assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_pop};

    // A word written this cycle into the slot that becomes the head bypasses the array.
    assign w_head_next = (w_push && (w_rd_next[AW-1:0] == r_wr_ptr[AW-1:0]))
                       ? i_push_data : r_mem[w_rd_next[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push && !i_clear) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_next;
            r_head   <= w_head_next;
        end
    end

    assign o_data  = r_head;
    assign o_valid = ~w_empty;
    assign o_full  = w_full;

endmodule

// File: rtl/match_event_logger.sv
// rtl/match_event_logger.sv - timestamps detector match pulses, buffers them and keeps status counters
module match_event_logger
    import match_event_logger_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_enable,
    input  logic                   i_clear,
    input  logic                   i_match_in,
    match_event_logger_if.master   ts_if,
    output logic [CNT_W-1:0]       o_match_count,
    output logic                   o_overflow
);

    logic [TS_W-1:0]  r_ts;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_drop;
    logic [TS_W-1:0]  w_head;
    logic             w_valid;

    // clear wins over a same-cycle match or read.
    assign w_push = i_match_in & i_enable & ~i_clear;
    assign w_pop  = w_valid & ts_if.ts_ready & ~i_clear;
    assign w_drop = w_push & w_full & ~w_pop;

    sync_fifo_fwft #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (i_clear),
        .i_push      (w_push),
        .i_push_data (r_ts),
        .i_pop       (w_pop),
        .o_data      (w_head),
        .o_valid     (w_valid),
        .o_full      (w_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ts       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_ts       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (i_enable) begin
                r_ts <= r_ts + 1'b1;
            end
            if (w_push && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign ts_if.ts_data  = w_head;
    assign ts_if.ts_valid = w_valid;
    assign o_match_count  = r_count;
    assign o_overflow     = r_overflow;

endmodule
